// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for a whole
// bus cycle, plus a watchdog that aborts slave cycles that never get acked.
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [29:0] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [29:0] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [29:0] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  localparam int unsigned     TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TO_LAST);

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic            owner, owner_nxt;
  logic [TO_W-1:0] wdog, wdog_nxt;

  logic granted;
  logic cur;
  logic cur_cyc;
  logic cur_stb;
  logic timeout_hit;

  assign granted = (state == GNT0) || (state == GNT1);
  assign cur     = (state == GNT1);
  assign cur_cyc = cur ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = cur ? m1_stb_i : m0_stb_i;

  // Ack on the final watchdog cycle takes precedence over the abort.
  assign timeout_hit = (TIMEOUT != 0) && granted && cur_cyc && cur_stb &&
                       !s_ack_i && (wdog == WDOG_LAST);

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign m0_ack_o  = (state == GNT0) && s_ack_i;
  assign m1_ack_o  = (state == GNT1) && s_ack_i;
  assign m0_err_o  = (state == GNT0) && timeout_hit;
  assign m1_err_o  = (state == GNT1) && timeout_hit;
  assign gnt_o     = {state == GNT1, state == GNT0};

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    s_sel_o  = '0;
    s_data_o = '0;
    if (state == GNT0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
      s_sel_o  = m0_sel_i;
      s_data_o = m0_data_i;
    end else if (state == GNT1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
      s_sel_o  = m1_sel_i;
      s_data_o = m1_data_i;
    end
  end

  // last names the most recent owner, so contention goes to the other master.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    wdog_nxt  = '0;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!cur_cyc) begin
          state_nxt = IDLE;
          last_nxt  = cur;
        end else if (timeout_hit) begin
          state_nxt = ABORT;
          owner_nxt = cur;
        end else if (s_stb_o && !s_ack_i) begin
          wdog_nxt = wdog + TO_W'(1);
        end
      end
      ABORT: begin
        if (!(owner ? m1_cyc_i : m0_cyc_i)) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
      wdog  <= wdog_nxt;
    end
  end

endmodule
